// File: rtl/vegeta_pu_mx_pkg.sv
// Shared types, default widths and the saturating adder for the MX sparse PU row.
package vTPU_pkg_mx;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    LOAD = 2'b01,
    COMP = 2'b10,
    CLR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    DENSE  = 2'b00,
    SPARSE = 2'b01
  } gemm_e;

  localparam int unsigned ELEM_W_DEF     = 8;
  localparam int unsigned ADD_W_DEF      = 24;
  localparam int unsigned SCALE_W_DEF    = 8;
  localparam int unsigned SCALE_BIAS_DEF = 127;

  // Signed add clamped to the range of a W-bit two's-complement value (W <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/vegeta_pu_mx_mac.sv
// One sparse MAC lane: double-buffered {meta, weight}, slot select, multiply, align and add.
module vegeta_mac_mx
  import vTPU_pkg_mx::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned M      = 4,
  parameter int unsigned META_W = $clog2(M),
  parameter int unsigned ADD_W  = ADD_W_DEF,
  parameter int unsigned SH_W   = $clog2(ADD_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     load_en,
  input  logic                     wb_sel,
  input  logic                     cap_en,
  input  logic                     s2_en,
  input  logic                     sparse,
  input  logic [ELEM_W+META_W-1:0] weight_in,
  input  logic [M*ELEM_W-1:0]      act_in,
  input  logic [ADD_W-1:0]         acc_in,
  input  logic                     shift_prod,
  input  logic [SH_W-1:0]          sh,
  output logic [ADD_W-1:0]         acc_out,
  output logic                     sat
);

  localparam int unsigned LANE_W = ELEM_W + META_W;

  logic [LANE_W-1:0]          buf_q [2];
  logic [LANE_W-1:0]          cur;
  logic [META_W-1:0]          slot;
  logic signed [ELEM_W-1:0]   w_s;
  logic signed [ELEM_W-1:0]   a_s;
  logic signed [2*ELEM_W-1:0] prod;
  logic signed [ADD_W-1:0]    prod_q;
  logic signed [ADD_W-1:0]    acc_q;
  logic signed [ADD_W-1:0]    a_sh;
  logic signed [ADD_W-1:0]    b_sh;
  logic signed [63:0]         raw;
  logic signed [63:0]         sum;

  // Compute always reads the buffer that is not being loaded.
  always_comb begin
    cur  = wb_sel ? buf_q[0] : buf_q[1];
    w_s  = cur[ELEM_W-1:0];
    slot = sparse ? cur[LANE_W-1:ELEM_W] : '0;
    a_s  = '0;
    for (int s = 0; s < int'(M); s++) begin
      if (META_W'(s) == slot) begin
        a_s = act_in[s*ELEM_W +: ELEM_W];
      end
    end
    prod = (2*ELEM_W)'(w_s) * (2*ELEM_W)'(a_s);
  end

  always_comb begin
    a_sh = shift_prod ? (prod_q >>> sh) : prod_q;
    b_sh = shift_prod ? acc_q : (acc_q >>> sh);
    raw  = 64'(a_sh) + 64'(b_sh);
    sum  = sat_add(64'(a_sh), 64'(b_sh), ADD_W);
    sat  = (sum != raw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      acc_out  <= '0;
    end else begin
      if (clr) begin
        buf_q[0] <= '0;
        buf_q[1] <= '0;
      end else if (load_en) begin
        buf_q[wb_sel] <= weight_in;
      end
      if (cap_en) begin
        prod_q <= ADD_W'(prod);
        acc_q  <= acc_in;
      end
      if (clr) begin
        acc_out <= '0;
      end else if (s2_en) begin
        acc_out <= sum[ADD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vegeta_pu_mx.sv
// One systolic row of MX-scaled sparse MAC lanes with a shared exponent path and weight chain.
module vegeta_pu_mx
  import vTPU_pkg_mx::*;
#(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned ELEM_W     = ELEM_W_DEF,
  parameter int unsigned M          = 4,
  parameter int unsigned META_W     = $clog2(M),
  parameter int unsigned ADD_W      = ADD_W_DEF,
  parameter int unsigned SCALE_W    = SCALE_W_DEF,
  parameter int unsigned SCALE_BIAS = SCALE_BIAS_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            mode,
  input  logic [1:0]                            gemm_mode,
  input  logic                                  i_wb,
  input  logic                                  weight_transferring_in,
  input  logic [NUM_LANES*(ELEM_W+META_W)-1:0]  weight_in,
  input  logic [NUM_LANES*M*ELEM_W-1:0]         act_in,
  input  logic                                  acc_valid_in,
  input  logic [NUM_LANES*ADD_W-1:0]            acc_in,
  input  logic [SCALE_W-1:0]                    input_scale,
  input  logic [SCALE_W-1:0]                    weight_scale,
  input  logic [SCALE_W-1:0]                    input_acc_scale,
  output logic                                  acc_valid_out,
  output logic [NUM_LANES*ADD_W-1:0]            acc_out,
  output logic [SCALE_W-1:0]                    output_acc_scale,
  output logic [NUM_LANES*(ELEM_W+META_W)-1:0]  weight_out,
  output logic                                  weight_transferring_out,
  output logic                                  acc_ovf
);

  localparam int unsigned LANE_W = ELEM_W + META_W;
  localparam int unsigned SH_W   = $clog2(ADD_W);
  localparam int unsigned PS_W   = SCALE_W + 2;

  mode_e                  mode_s;
  logic                   load_en;
  logic                   cap_en;
  logic                   clr;
  logic                   sparse;
  logic signed [PS_W-1:0] ps_raw;
  logic [SCALE_W-1:0]     ps;
  logic [SCALE_W-1:0]     ps_q;
  logic [SCALE_W-1:0]     acc_scale_q;
  logic                   v1_q;
  logic                   shift_prod;
  logic [SCALE_W-1:0]     os;
  logic [SCALE_W-1:0]     d;
  logic [SH_W-1:0]        sh;
  logic [NUM_LANES-1:0]   lane_sat;

  assign mode_s  = mode_e'(mode);
  assign load_en = (mode_s == LOAD) && weight_transferring_in;
  assign cap_en  = (mode_s == COMP) && acc_valid_in;
  assign clr     = (mode_s == CLR);
  assign sparse  = (gemm_mode == SPARSE);

  // Product exponent, widened so the bias subtraction can go negative before clamping.
  always_comb begin
    ps_raw = signed'({2'b00, input_scale}) + signed'({2'b00, weight_scale})
             - signed'(PS_W'(SCALE_BIAS));
    if (ps_raw[PS_W-1]) begin
      ps = '0;
    end else if (|ps_raw[PS_W-2:SCALE_W]) begin
      ps = '1;
    end else begin
      ps = ps_raw[SCALE_W-1:0];
    end
  end

  always_comb begin
    shift_prod = (ps_q < acc_scale_q);
    os         = shift_prod ? acc_scale_q : ps_q;
    d          = shift_prod ? (acc_scale_q - ps_q) : (ps_q - acc_scale_q);
    sh         = (32'(d) > ADD_W - 1) ? SH_W'(ADD_W - 1) : d[SH_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q                    <= '0;
      acc_scale_q             <= '0;
      v1_q                    <= 1'b0;
      acc_valid_out           <= 1'b0;
      output_acc_scale        <= '0;
      acc_ovf                 <= 1'b0;
      weight_out              <= '0;
      weight_transferring_out <= 1'b0;
    end else begin
      weight_out              <= weight_in;
      weight_transferring_out <= weight_transferring_in;
      if (cap_en) begin
        ps_q        <= ps;
        acc_scale_q <= input_acc_scale;
      end
      if (clr) begin
        v1_q          <= 1'b0;
        acc_valid_out <= 1'b0;
        acc_ovf       <= 1'b0;
      end else begin
        v1_q          <= cap_en;
        acc_valid_out <= v1_q;
        if (v1_q) begin
          output_acc_scale <= os;
          if (|lane_sat) begin
            acc_ovf <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    vegeta_mac_mx #(
      .ELEM_W (ELEM_W),
      .M      (M),
      .META_W (META_W),
      .ADD_W  (ADD_W),
      .SH_W   (SH_W)
    ) u_mac (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .load_en    (load_en),
      .wb_sel     (i_wb),
      .cap_en     (cap_en),
      .s2_en      (v1_q),
      .sparse     (sparse),
      .weight_in  (weight_in[i*LANE_W +: LANE_W]),
      .act_in     (act_in[i*M*ELEM_W +: M*ELEM_W]),
      .acc_in     (acc_in[i*ADD_W +: ADD_W]),
      .shift_prod (shift_prod),
      .sh         (sh),
      .acc_out    (acc_out[i*ADD_W +: ADD_W]),
      .sat        (lane_sat[i])
    );
  end

endmodule

// File: tb/tb_vegeta_pu_mx.sv
// Directed self-checking bench for vegeta_pu_mx with hand-computed expectations.
module tb_vegeta_pu_mx;

  localparam int NL = 4;
  localparam int EW = 8;
  localparam int MM = 4;
  localparam int MW = 2;
  localparam int AW = 24;
  localparam int SW = 8;
  localparam int LW = EW + MW;

  logic              clk;
  logic              rst_n;
  logic [1:0]        mode;
  logic [1:0]        gemm_mode;
  logic              i_wb;
  logic              wti;
  logic [NL*LW-1:0]  weight_in;
  logic [NL*MM*EW-1:0] act_in;
  logic              avi;
  logic [NL*AW-1:0]  acc_in;
  logic [SW-1:0]     input_scale;
  logic [SW-1:0]     weight_scale;
  logic [SW-1:0]     input_acc_scale;
  logic              acc_valid_out;
  logic [NL*AW-1:0]  acc_out;
  logic [SW-1:0]     output_acc_scale;
  logic [NL*LW-1:0]  weight_out;
  logic              wto;
  logic              acc_ovf;

  int   checks;
  int   errors;
  int   w_v [4];
  int   m_v [4];
  int   act_v [4][4];
  int   acc_v [4];
  int   exp_v [4];
  logic v_mid;

  vegeta_pu_mx u_dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .mode                    (mode),
    .gemm_mode               (gemm_mode),
    .i_wb                    (i_wb),
    .weight_transferring_in  (wti),
    .weight_in               (weight_in),
    .act_in                  (act_in),
    .acc_valid_in            (avi),
    .acc_in                  (acc_in),
    .input_scale             (input_scale),
    .weight_scale            (weight_scale),
    .input_acc_scale         (input_acc_scale),
    .acc_valid_out           (acc_valid_out),
    .acc_out                 (acc_out),
    .output_acc_scale        (output_acc_scale),
    .weight_out              (weight_out),
    .weight_transferring_out (wto),
    .acc_ovf                 (acc_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pack_w();
    for (int i = 0; i < NL; i++) weight_in[i*LW +: LW] = {m_v[i][MW-1:0], w_v[i][EW-1:0]};
  endtask

  task automatic pack_a();
    for (int i = 0; i < NL; i++) begin
      for (int s = 0; s < MM; s++) act_in[(i*MM+s)*EW +: EW] = act_v[i][s][EW-1:0];
      acc_in[i*AW +: AW] = acc_v[i][AW-1:0];
    end
  endtask

  task automatic load_buf(input logic b);
    pack_w();
    i_wb = b; mode = 2'b01; wti = 1'b1;
    @(negedge clk);
    mode = 2'b00; wti = 1'b0;
  endtask

  task automatic run_compute(input logic b, input logic [1:0] gm);
    pack_a();
    i_wb = b; gemm_mode = gm; mode = 2'b10; avi = 1'b1;
    @(negedge clk);
    mode = 2'b00; avi = 1'b0;
    v_mid = acc_valid_out;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int got;
    rst_n = 1'b0; mode = 2'b00; gemm_mode = 2'b00; i_wb = 1'b0; avi = 1'b0;
    wti = 1'b1; weight_in = '1; act_in = '0; acc_in = '1;
    input_scale = 8'd127; weight_scale = 8'd127; input_acc_scale = 8'd127;
    repeat (2) @(negedge clk);
    checks++;
    if (acc_valid_out !== 1'b0 || acc_ovf !== 1'b0 || wto !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b ovf=%b wto=%b want 0 0 0", acc_valid_out, acc_ovf, wto);
    end
    checks++;
    if (acc_out !== '0 || weight_out !== '0 || output_acc_scale !== '0) begin
      errors++;
      $display("FAIL reset_data got acc=%h wo=%h sc=%0d want 0", acc_out, weight_out,
               output_acc_scale);
    end
    rst_n = 1'b1; wti = 1'b0; weight_in = '0; acc_in = '0;
    @(negedge clk);
    got = 0;
    checks++;
    if (acc_valid_out !== 1'b0 || 32'(acc_out) != got) begin
      errors++;
      $display("FAIL reset_release got v=%b acc=%h want 0", acc_valid_out, acc_out);
    end
  endtask

  task automatic test_dense();
    int got;
    w_v = '{3, -1, 5, 2}; m_v = '{0, 0, 0, 0};
    load_buf(1'b0);
    act_v[0] = '{5, 11, 12, 13};   act_v[1] = '{4, 11, 12, 13};
    act_v[2] = '{-3, 11, 12, 13};  act_v[3] = '{100, 11, 12, 13};
    acc_v = '{10, -7, 0, 1000};
    exp_v = '{25, -11, -15, 1200};
    run_compute(1'b1, 2'b00);
    checks++;
    if (v_mid !== 1'b0 || acc_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL dense_latency got mid=%b out=%b want 0 1", v_mid, acc_valid_out);
    end
    for (int i = 0; i < NL; i++) begin
      got = 32'($signed(acc_out[i*AW +: AW]));
      checks++;
      if (got !== exp_v[i]) begin
        errors++;
        $display("FAIL dense_lane%0d got %0d want %0d", i, got, exp_v[i]);
      end
    end
    checks++;
    if (output_acc_scale !== 8'd127) begin
      errors++;
      $display("FAIL dense_scale got %0d want 127", output_acc_scale);
    end
    @(negedge clk);
    got = 32'($signed(acc_out[0 +: AW]));
    checks++;
    if (acc_valid_out !== 1'b0 || got !== 25) begin
      errors++;
      $display("FAIL dense_hold got v=%b acc0=%0d want 0 25", acc_valid_out, got);
    end
  endtask

  task automatic test_align();
    int got;
    int is_t [5] = '{128, 127, 0, 255, 127};
    int ws_t [5] = '{127, 127, 0, 255, 167};
    int as_t [5] = '{127, 129, 3, 255, 127};
    int sc_t [5] = '{128, 129, 3, 255, 167};
    int ex_t [5][4] = '{'{20, -8, -15, 700}, '{13, -8, -4, 1050}, '{11, -8, -2, 1025},
                        '{25, -11, -15, 1200}, '{15, -5, -15, 200}};
    acc_v = '{10, -7, 0, 1000};
    for (int c = 0; c < 5; c++) begin
      input_scale = is_t[c][SW-1:0]; weight_scale = ws_t[c][SW-1:0];
      input_acc_scale = as_t[c][SW-1:0];
      run_compute(1'b1, 2'b00);
      for (int i = 0; i < NL; i++) begin
        got = 32'($signed(acc_out[i*AW +: AW]));
        checks++;
        if (got !== ex_t[c][i]) begin
          errors++;
          $display("FAIL align%0d_lane%0d got %0d want %0d", c, i, got, ex_t[c][i]);
        end
      end
      checks++;
      if (32'(output_acc_scale) !== sc_t[c] || acc_valid_out !== 1'b1) begin
        errors++;
        $display("FAIL align%0d_scale got %0d v=%b want %0d 1", c, output_acc_scale,
                 acc_valid_out, sc_t[c]);
      end
    end
    input_scale = 8'd127; weight_scale = 8'd127; input_acc_scale = 8'd127;
  endtask

  task automatic test_sparse();
    int got;
    logic [1:0] gm_t [3] = '{2'b01, 2'b00, 2'b10};
    int ex_t [3][4] = '{'{82, 28, 46, 3}, '{98, 4, 49, 3}, '{98, 4, 49, 3}};
    w_v = '{-2, 4, -1, 6}; m_v = '{2, 3, 1, 0};
    load_buf(1'b1);
    for (int i = 0; i < NL; i++) act_v[i] = '{1, 4, 9, 7};
    acc_v = '{100, 0, 50, -3};
    for (int c = 0; c < 3; c++) begin
      run_compute(1'b0, gm_t[c]);
      for (int i = 0; i < NL; i++) begin
        got = 32'($signed(acc_out[i*AW +: AW]));
        checks++;
        if (got !== ex_t[c][i]) begin
          errors++;
          $display("FAIL sparse%0d_lane%0d got %0d want %0d", c, i, got, ex_t[c][i]);
        end
      end
    end
    checks++;
    if (acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idle got %b want 0", acc_ovf);
    end
  endtask

  task automatic test_saturation();
    int got;
    int ex_t [2][4] = '{'{8388607, -8388608, 15, 7}, '{100, -100, 10, 0}};
    w_v = '{10, -10, 1, 0}; m_v = '{0, 0, 0, 0};
    load_buf(1'b0);
    for (int i = 0; i < NL; i++) act_v[i] = '{10, 0, 0, 0};
    for (int c = 0; c < 2; c++) begin
      if (c == 0) acc_v = '{8388607, -8388608, 5, 7};
      else acc_v = '{0, 0, 0, 0};
      run_compute(1'b1, 2'b00);
      for (int i = 0; i < NL; i++) begin
        got = 32'($signed(acc_out[i*AW +: AW]));
        checks++;
        if (got !== ex_t[c][i]) begin
          errors++;
          $display("FAIL sat%0d_lane%0d got %0d want %0d", c, i, got, ex_t[c][i]);
        end
      end
      checks++;
      if (acc_ovf !== 1'b1) begin
        errors++;
        $display("FAIL sat%0d_ovf got %b want 1", c, acc_ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got;
    logic [NL*LW-1:0] p1, p2, p3;
    int ex_t [5] = '{7, -1, 15, 114, 114};
    logic exv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    w_v = '{3, 3, 3, 3}; m_v = '{0, 0, 0, 0};
    load_buf(1'b0);
    for (int i = 0; i < NL; i++) begin act_v[i] = '{2, 0, 0, 0}; acc_v[i] = 1; end
    pack_a();
    p1 = 40'h12_3456_789a; weight_in = p1; wti = 1'b0;
    i_wb = 1'b1; gemm_mode = 2'b00; mode = 2'b10; avi = 1'b1;
    @(negedge clk);
    checks++;
    if (weight_out !== p1 || wto !== 1'b0) begin
      errors++;
      $display("FAIL chain0 got %h/%b want %h/0", weight_out, wto, p1);
    end
    w_v = '{7, 7, 7, 7}; pack_w(); p2 = weight_in;
    wti = 1'b1; mode = 2'b01; avi = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (acc_valid_out !== exv[c]) begin
        errors++;
        $display("FAIL b2b%0d_valid got %b want %b", c, acc_valid_out, exv[c]);
      end
      if (exv[c] || c == 4) begin
        for (int i = 0; i < NL; i++) begin
          got = 32'($signed(acc_out[i*AW +: AW]));
          checks++;
          if (got !== ex_t[c]) begin
            errors++;
            $display("FAIL b2b%0d_lane%0d got %0d want %0d", c, i, got, ex_t[c]);
          end
        end
      end
      if (c == 0) begin
        checks++;
        if (weight_out !== p2 || wto !== 1'b1) begin
          errors++;
          $display("FAIL chain1 got %h/%b want %h/1", weight_out, wto, p2);
        end
        w_v = '{5, 5, 5, 5}; pack_w(); p3 = weight_in;
        mode = 2'b10; i_wb = 1'b0; avi = 1'b1;
      end else if (c == 1) begin
        checks++;
        if (weight_out !== p3 || wto !== 1'b1) begin
          errors++;
          $display("FAIL chain2 got %h/%b want %h/1", weight_out, wto, p3);
        end
        for (int i = 0; i < NL; i++) acc_v[i] = 100;
        pack_a(); wti = 1'b0;
      end else if (c == 2) begin
        mode = 2'b00; avi = 1'b0;
      end
    end
  endtask

  task automatic test_ignore_valid();
    int got;
    logic [1:0] md_t [2] = '{2'b00, 2'b01};
    for (int c = 0; c < 2; c++) begin
      mode = md_t[c]; avi = 1'b1; wti = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        got = 32'($signed(acc_out[0 +: AW]));
        checks++;
        if (acc_valid_out !== 1'b0 || got !== 114) begin
          errors++;
          $display("FAIL ignore_m%0d_c%0d got v=%b acc0=%0d want 0 114", md_t[c], k,
                   acc_valid_out, got);
        end
      end
    end
    mode = 2'b00; avi = 1'b0;
  endtask

  task automatic test_kill(input logic use_rst);
    int got;
    for (int i = 0; i < NL; i++) acc_v[i] = 1;
    pack_a();
    i_wb = 1'b0; mode = 2'b10; avi = 1'b1;
    @(negedge clk);
    avi = 1'b0;
    if (use_rst) begin mode = 2'b00; rst_n = 1'b0; end
    else mode = 2'b11;
    @(negedge clk);
    checks++;
    if (acc_valid_out !== 1'b0 || acc_out !== '0 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL kill%0d_state got v=%b acc=%h ovf=%b want 0 0 0", use_rst, acc_valid_out,
               acc_out, acc_ovf);
    end
    mode = 2'b00; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (acc_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL kill%0d_late_valid got %b want 0", use_rst, acc_valid_out);
    end
    for (int b = 0; b < 2; b++) begin
      acc_v = (b == 0) ? '{5, 6, 7, 8} : '{-1, -2, -3, -4};
      run_compute(b[0], 2'b00);
      for (int i = 0; i < NL; i++) begin
        got = 32'($signed(acc_out[i*AW +: AW]));
        checks++;
        if (got !== acc_v[i]) begin
          errors++;
          $display("FAIL kill%0d_buf%0d_lane%0d got %0d want %0d", use_rst, b, i, got,
                   acc_v[i]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_dense();
    test_align();
    test_sparse();
    test_saturation();
    test_back_to_back();
    test_ignore_valid();
    test_kill(1'b0);
    w_v = '{3, 3, 3, 3}; m_v = '{0, 0, 0, 0};
    load_buf(1'b0);
    load_buf(1'b1);
    test_kill(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
